// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer register block: register offsets,
// CTRL/STATUS bit positions and the completer FSM state type.
package apb_timer_pkg;

  localparam logic [3:0] LOAD_OFS   = 4'h0;
  localparam logic [3:0] CTRL_OFS   = 4'h4;
  localparam logic [3:0] COUNT_OFS  = 4'h8;
  localparam logic [3:0] STATUS_OFS = 4'hC;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int STATUS_INTR_BIT = 0;

  localparam int WCNT_W = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_cmp_state_t;

endpackage

// File: rtl/apb_if.sv
// APB3 bus bundle between the system fabric (master) and a completer (slave).
interface apb_if #(
  parameter int ADDR_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic              pready;
  logic [31:0]       prdata;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_timer_irq_sticky.sv
// Timer interrupt capture: rising-edge detect on intr_req_i, sticky INTR flag
// with write-one-to-clear, and IRQ_EN masking of the outgoing interrupt.
module apb_timer_irq_sticky (
  input  logic clk,
  input  logic rst_n,
  input  logic intr_req_i,
  input  logic clr_i,
  input  logic irq_en_i,
  output logic intr_o,
  output logic irq_o
);

  logic req_dly_q;
  logic intr_q, intr_d;
  logic rise_s;

  assign rise_s = intr_req_i & ~req_dly_q;

  // A new edge wins over a simultaneous clear so no event is lost.
  always_comb begin
    intr_d = intr_q;
    if (rise_s) begin
      intr_d = 1'b1;
    end else if (clr_i) begin
      intr_d = 1'b0;
    end else begin
      intr_d = intr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_dly_q <= 1'b0;
      intr_q    <= 1'b0;
    end else begin
      req_dly_q <= intr_req_i;
      intr_q    <= intr_d;
    end
  end

  assign intr_o = intr_q;
  assign irq_o  = intr_q & irq_en_i;

endmodule

// File: rtl/apb_timer_regs.sv
// APB3 completer for the countdown timer: LOAD/CTRL registers driving the core,
// COUNT readback and sticky interrupt STATUS, with configurable wait states.
module apb_timer_regs
  import apb_timer_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  apb_if.slave        apb,
  output logic [15:0] load_o,
  output logic        en_o,
  input  logic [15:0] count_i,
  input  logic        intr_req_i,
  output logic        irq_o
);

  localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(WAIT_STATES);

  apb_cmp_state_t    state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [15:0]       load_q, load_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic              pready_s, addr_ok_s, wr_en_s, w1c_s, intr_s;
  logic [3:0]        ofs_s;
  logic [31:0]       rdata_s;
  logic              unused_s;

  assign ofs_s     = {apb.paddr[3:2], 2'b00};
  assign addr_ok_s = (apb.paddr[ADDR_W-1:4] == '0);
  assign pready_s  = (state_q == ACCESS) && (wcnt_q == '0);
  assign wr_en_s   = apb.psel & apb.penable & apb.pwrite & pready_s & addr_ok_s;
  assign unused_s  = ^{apb.paddr[1:0], apb.pwdata[31:16]};

  // Completer FSM: setup loads the wait counter, access drains it; dropping psel aborts.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          state_d = ACCESS;
          wcnt_d  = WAIT_INIT;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!apb.psel) begin
          state_d = IDLE;
        end else if (pready_s && apb.penable) begin
          state_d = IDLE;
        end else if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - 1'b1;
        end else begin
          wcnt_d = wcnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    load_d = load_q;
    ctrl_d = ctrl_q;
    w1c_s  = 1'b0;
    if (wr_en_s) begin
      case (ofs_s)
        LOAD_OFS:   load_d = apb.pwdata[15:0];
        CTRL_OFS:   ctrl_d = apb.pwdata[1:0];
        STATUS_OFS: w1c_s  = apb.pwdata[STATUS_INTR_BIT];
        default:    w1c_s  = 1'b0;
      endcase
    end else begin
      w1c_s = 1'b0;
    end
  end

  always_comb begin
    rdata_s = 32'h0;
    case (ofs_s)
      LOAD_OFS:   rdata_s = {16'h0, load_q};
      CTRL_OFS:   rdata_s = {30'h0, ctrl_q};
      COUNT_OFS:  rdata_s = {16'h0, count_i};
      STATUS_OFS: rdata_s = {31'h0, intr_s};
      default:    rdata_s = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      load_q  <= 16'h0;
      ctrl_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      load_q  <= load_d;
      ctrl_q  <= ctrl_d;
    end
  end

  apb_timer_irq_sticky u_irq (
    .clk        (clk),
    .rst_n      (rst_n),
    .intr_req_i (intr_req_i),
    .clr_i      (w1c_s),
    .irq_en_i   (ctrl_q[CTRL_IRQ_EN_BIT]),
    .intr_o     (intr_s),
    .irq_o      (irq_o)
  );

  assign apb.pready  = pready_s;
  assign apb.prdata  = (pready_s && addr_ok_s) ? rdata_s : 32'h0;
  assign apb.pslverr = pready_s & ~addr_ok_s;
  assign load_o      = load_q;
  assign en_o        = ctrl_q[CTRL_EN_BIT];

endmodule

// File: tb/tb_apb_timer_regs.sv
// Directed plus randomized bench for apb_timer_regs; two instances cover
// zero and three wait states against a register-level reference model.
module tb_apb_timer_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cnt0 = 16'h0, cnt3 = 16'h0;
  logic        intr0 = 1'b0, intr3 = 1'b0;
  logic [15:0] load0, load3;
  logic        en0, en3, irq0, irq3;

  int checks = 0;
  int errors = 0;

  logic [15:0] load_m [2];
  logic [1:0]  ctrl_m [2];
  logic        intr_m [2];

  apb_if #(.ADDR_W(8)) bus0 ();
  apb_if #(.ADDR_W(8)) bus3 ();

  always #5 clk = ~clk;

  apb_timer_regs #(.ADDR_W(8), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .apb(bus0), .load_o(load0), .en_o(en0),
    .count_i(cnt0), .intr_req_i(intr0), .irq_o(irq0));

  apb_timer_regs #(.ADDR_W(8), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .apb(bus3), .load_o(load3), .en_o(en3),
    .count_i(cnt3), .intr_req_i(intr3), .irq_o(irq3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit d3, input logic s, input logic e, input logic w,
                       input logic [7:0] a, input logic [31:0] wd);
    if (d3) begin
      bus3.psel = s; bus3.penable = e; bus3.pwrite = w; bus3.paddr = a; bus3.pwdata = wd;
    end else begin
      bus0.psel = s; bus0.penable = e; bus0.pwrite = w; bus0.paddr = a; bus0.pwdata = wd;
    end
  endtask

  function automatic logic rdy(input bit d3);
    return d3 ? bus3.pready : bus0.pready;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      load_m[i] = 16'h0; ctrl_m[i] = 2'b00; intr_m[i] = 1'b0;
    end
  endtask

  // Register-level behaviour: returns read data / error and applies the write.
  task automatic model_access(input int d, input logic [7:0] a, input logic w,
                              input logic [31:0] wd, input logic [15:0] cnt,
                              output logic [31:0] rd, output logic err);
    rd = 32'h0; err = 1'b0;
    if (a >= 8'h10) begin
      err = 1'b1;
    end else begin
      case (a[3:0] & 4'hC)
        4'h0: begin rd = 32'(load_m[d]); if (w) load_m[d] = wd[15:0]; end
        4'h4: begin rd = 32'(ctrl_m[d]); if (w) ctrl_m[d] = wd[1:0]; end
        4'h8: rd = 32'(cnt);
        default: begin rd = 32'(intr_m[d]); if (w && wd[0]) intr_m[d] = 1'b0; end
      endcase
    end
  endtask

  task automatic xfer(input bit d3, input logic [7:0] a, input logic w, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int waits);
    drive(d3, 1'b1, 1'b0, w, a, wd);
    @(posedge clk); #1;
    drive(d3, 1'b1, 1'b1, w, a, wd);
    waits = 0;
    @(negedge clk);
    while (!rdy(d3) && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    rd  = d3 ? bus3.prdata  : bus0.prdata;
    err = d3 ? bus3.pslverr : bus0.pslverr;
    @(posedge clk); #1;
    drive(d3, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  // One checked transfer: model first, then bus, then the registered outputs.
  task automatic checked(input bit d3, input logic [7:0] a, input logic w, input logic [31:0] wd);
    logic [31:0] rd, erd;
    logic        err, eerr;
    int          waits;
    int          d;
    d = d3 ? 1 : 0;
    model_access(d, a, w, wd, d3 ? cnt3 : cnt0, erd, eerr);
    xfer(d3, a, w, wd, rd, err, waits);
    chk("wait_cycles", 32'(waits), d3 ? 32'd3 : 32'd0);
    chk("pslverr", 32'(err), 32'(eerr));
    if (!w) chk("prdata", rd, erd);
    chk("load_o", d3 ? 32'(load3) : 32'(load0), 32'(load_m[d]));
    chk("en_o", d3 ? 32'(en3) : 32'(en0), 32'(ctrl_m[d][0]));
    chk("irq_o", d3 ? 32'(irq3) : 32'(irq0), 32'(intr_m[d] & ctrl_m[d][1]));
  endtask

  logic [7:0] addrs [8];

  initial begin
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h40, 8'hF0};
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);

    // Reset held: every output at zero.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready", 32'(bus0.pready), 32'd0);
    chk("rst_prdata", bus0.prdata, 32'h0);
    chk("rst_pslverr", 32'(bus0.pslverr), 32'd0);
    chk("rst_load", 32'(load0), 32'h0);
    chk("rst_en_irq", {30'h0, en3, irq0}, 32'h0);
    rst_n = 1'b1;
    checked(1'b0, 8'h00, 1'b0, 32'h0);
    checked(1'b0, 8'h04, 1'b0, 32'h0);
    checked(1'b0, 8'h0C, 1'b0, 32'h0);

    // Zero wait states: LOAD write and readback.
    checked(1'b0, 8'h00, 1'b1, 32'h0000_1234);
    checked(1'b0, 8'h00, 1'b0, 32'h0);

    // Three wait states: COUNT read.
    cnt3 = 16'h00AA;
    checked(1'b1, 8'h08, 1'b0, 32'h0);

    // Interrupt: set, readback, W1C clear, set wins over clear.
    checked(1'b0, 8'h04, 1'b1, 32'h3);
    @(posedge clk); #1 intr0 = 1'b1;
    @(posedge clk); #1 intr0 = 1'b0;
    intr_m[0] = 1'b1;
    chk("irq_set", 32'(irq0), 32'd1);
    checked(1'b0, 8'h0C, 1'b0, 32'h0);
    checked(1'b0, 8'h0C, 1'b1, 32'h1);
    chk("irq_cleared", 32'(irq0), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h0C, 32'h1);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h0C, 32'h1);
    intr0 = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    intr0 = 1'b0;
    intr_m[0] = 1'b1;
    chk("set_beats_clr", 32'(irq0), 32'd1);
    checked(1'b0, 8'h0C, 1'b0, 32'h0);

    // Out-of-range address: error, LOAD untouched.
    checked(1'b0, 8'h10, 1'b1, 32'h0000_FFFF);
    checked(1'b0, 8'h00, 1'b0, 32'h0);

    // Protocol abort in the wait phase leaves LOAD untouched.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0000_BEEF);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 32'h0000_BEEF);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_pready", 32'(bus3.pready), 32'd0);
    chk("abort_load", 32'(load3), 32'h0);

    // Reset during the access phase of a CTRL write.
    checked(1'b1, 8'h04, 1'b1, 32'h1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h04, 32'h2);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h04, 32'h2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_pready", 32'(bus3.pready), 32'd0);
    chk("mid_rst_en", 32'(en3), 32'd0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_pready", 32'(bus3.pready), 32'd0);
    checked(1'b1, 8'h00, 1'b1, 32'h0000_55AA);
    checked(1'b1, 8'h04, 1'b0, 32'h0);

    // Randomized traffic on both instances.
    for (int n = 0; n < 40; n++) begin
      bit d3;
      d3 = (n % 4 == 3);
      if (d3) cnt3 = 16'($urandom); else cnt0 = 16'($urandom);
      checked(d3, addrs[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
